// File: rtl/cam_vga_pkg.sv
// Shared constants for the camera-to-VGA read path: scale codes, RGB332
// colours and the vertical tracking state encoding.
package cam_vga_pkg;

  localparam logic [1:0] SCALE_X1 = 2'd0;
  localparam logic [1:0] SCALE_X2 = 2'd1;
  localparam logic [1:0] SCALE_X4 = 2'd2;

  localparam logic [7:0] RED   = 8'hE0;
  localparam logic [7:0] GREEN = 8'h1C;
  localparam logic [7:0] BLUE  = 8'h03;
  localparam logic [7:0] BLACK = 8'h00;

  typedef enum logic [1:0] {
    ST_WAIT_FRAME,
    ST_ABOVE,
    ST_IN_WIN,
    ST_BELOW
  } vstate_t;

  // Scale code to log2 of the upscale factor; the reserved code maps to x1.
  function automatic logic [1:0] scale_shift(input logic [1:0] scale);
    case (scale)
      SCALE_X2: return 2'd1;
      SCALE_X4: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/scaled_row_counter.sv
// Vertical window tracker: decides whether the current line lies inside the
// scaled window and keeps the source row base address without a multiplier.
module scaled_row_counter
  import cam_vga_pkg::*;
#(
  parameter int AW     = 15,
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int DISP_H = 480
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic [8:0]    pos_y,
  input  logic [1:0]    shift,
  input  logic [8:0]    win_y,
  output logic [AW-1:0] row_base,
  output logic          in_win
);

  vstate_t       state_reg, state_next, state_eff;
  logic [AW-1:0] row_base_reg, row_base_next;
  logic [1:0]    sub_row_reg, sub_row_next;
  logic [8:0]    pos_y_reg;
  logic          new_line;
  logic [11:0]   dy;
  logic [11:0]   win_h;
  logic [1:0]    sub_max;

  // Outputs describe the line currently presented, so the next-state values
  // are what the address path consumes in this same cycle.
  always_comb begin
    new_line      = (pos_y != pos_y_reg);
    dy            = {3'b000, pos_y} - {3'b000, win_y};
    win_h         = 12'(SRC_H) << shift;
    sub_max       = 2'((3'd1 << shift) - 3'd1);
    state_eff     = frame_start ? ST_ABOVE : state_reg;
    state_next    = state_eff;
    row_base_next = frame_start ? '0 : row_base_reg;
    sub_row_next  = frame_start ? '0 : sub_row_reg;
    case (state_eff)
      ST_ABOVE: begin
        if (pos_y == win_y && {3'b000, pos_y} < 12'(DISP_H)) begin
          state_next    = ST_IN_WIN;
          row_base_next = '0;
          sub_row_next  = '0;
        end
      end
      ST_IN_WIN: begin
        if (new_line) begin
          if (dy >= win_h || {3'b000, pos_y} >= 12'(DISP_H)) begin
            state_next = ST_BELOW;
          end else if (sub_row_reg == sub_max) begin
            sub_row_next  = '0;
            row_base_next = row_base_reg + AW'(SRC_W);
          end else begin
            sub_row_next = sub_row_reg + 2'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign in_win   = (state_next == ST_IN_WIN);
  assign row_base = row_base_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_WAIT_FRAME;
      row_base_reg <= '0;
      sub_row_reg  <= '0;
      pos_y_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      row_base_reg <= row_base_next;
      sub_row_reg  <= sub_row_next;
      pos_y_reg    <= pos_y;
    end
  end

endmodule

// File: rtl/frame_scaler_reader.sv
// Maps VGA raster positions onto an upscaled camera window in the frame
// buffer and formats the returned pixel, with border colour outside it.
module frame_scaler_reader
  import cam_vga_pkg::*;
#(
  parameter int AW      = 15,
  parameter int DW      = 8,
  parameter int SRC_W   = 160,
  parameter int SRC_H   = 120,
  parameter int DISP_W  = 640,
  parameter int DISP_H  = 480,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    scale,
  input  logic [9:0]    win_x,
  input  logic [8:0]    win_y,
  input  logic [DW-1:0] border_color,
  input  logic [9:0]    posX,
  input  logic [8:0]    posY,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] pixel_out,
  output logic          in_window,
  output logic          frame_start
);

  if (SRC_W * SRC_H > (1 << AW)) begin : g_addr_width_check
    $error("frame_scaler_reader: SRC_W*SRC_H does not fit in AW address bits");
  end
  if (RAM_LAT < 1) begin : g_ram_lat_check
    $error("frame_scaler_reader: RAM_LAT must be at least 1");
  end

  logic          prev_origin_reg;
  logic [1:0]    scale_reg;
  logic [9:0]    win_x_reg;
  logic [8:0]    win_y_reg;
  logic [DW-1:0] border_reg;

  logic          at_origin;
  logic          fs_now;
  logic [1:0]    shift_eff;
  logic [9:0]    win_x_eff;
  logic [8:0]    win_y_eff;
  logic [10:0]   rx;
  logic [10:0]   win_w;
  logic [10:0]   sx;
  logic          h_hit;
  logic          hit;
  logic          row_in_win;
  logic [AW-1:0] row_base;
  logic [AW-1:0] addr_next;
  logic          hit_dly;

  // The frame-start pixel itself must already see the new configuration,
  // so the incoming values bypass the shadow registers on that one cycle.
  always_comb begin
    at_origin = (posX == '0) && (posY == '0);
    fs_now    = at_origin && !prev_origin_reg;
    shift_eff = scale_shift(fs_now ? scale : scale_reg);
    win_x_eff = fs_now ? win_x : win_x_reg;
    win_y_eff = fs_now ? win_y : win_y_reg;
    rx        = {1'b0, posX} - {1'b0, win_x_eff};
    win_w     = 11'(SRC_W) << shift_eff;
    sx        = rx >> shift_eff;
    h_hit     = (posX >= win_x_eff) && (rx < win_w) && ({1'b0, posX} < 11'(DISP_W));
    hit       = row_in_win && h_hit;
    addr_next = hit ? (row_base + AW'(sx)) : '0;
  end

  scaled_row_counter #(
    .AW     (AW),
    .SRC_W  (SRC_W),
    .SRC_H  (SRC_H),
    .DISP_H (DISP_H)
  ) u_row_counter (
    .clk         (clk),
    .rst         (rst),
    .frame_start (fs_now),
    .pos_y       (posY),
    .shift       (shift_eff),
    .win_y       (win_y_eff),
    .row_base    (row_base),
    .in_win      (row_in_win)
  );

  // Hit flag delay line: stage 0 lines up with mem_addr, the last stage
  // with mem_data RAM_LAT cycles later.
  genvar gi;
  generate
    for (gi = 0; gi <= RAM_LAT; gi++) begin : g_hit_dly
      logic stage_reg;
      logic stage_in;
      if (gi == 0) begin : g_head
        assign stage_in = hit;
      end else begin : g_tail
        assign stage_in = g_hit_dly[gi-1].stage_reg;
      end
      always_ff @(posedge clk) begin
        if (rst) stage_reg <= 1'b0;
        else     stage_reg <= stage_in;
      end
    end
  endgenerate

  assign hit_dly = g_hit_dly[RAM_LAT].stage_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_origin_reg <= 1'b0;
      scale_reg       <= SCALE_X1;
      win_x_reg       <= '0;
      win_y_reg       <= '0;
      border_reg      <= '0;
      mem_addr        <= '0;
      frame_start     <= 1'b0;
      pixel_out       <= '0;
      in_window       <= 1'b0;
    end else begin
      prev_origin_reg <= at_origin;
      if (fs_now) begin
        scale_reg  <= scale;
        win_x_reg  <= win_x;
        win_y_reg  <= win_y;
        border_reg <= border_color;
      end
      mem_addr    <= addr_next;
      frame_start <= fs_now;
      pixel_out   <= hit_dly ? mem_data : border_reg;
      in_window   <= hit_dly;
    end
  end

endmodule

// File: tb/tb_frame_scaler_reader.sv
// Bench for frame_scaler_reader: compressed raster scans against a
// coordinate-arithmetic reference model, plus literal probe points.
module tb_frame_scaler_reader;
  import cam_vga_pkg::*;

  localparam int AW     = 15;
  localparam int SRC_W  = 160;
  localparam int SRC_H  = 120;
  localparam int NPIX   = SRC_W * SRC_H;
  localparam int NLINES = 500;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    scale;
  logic [9:0]    win_x;
  logic [8:0]    win_y;
  logic [7:0]    border_color;
  logic [9:0]    posX;
  logic [8:0]    posY;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic [7:0]    pixel_out;
  logic          in_window;
  logic          frame_start;

  always #20 clk = ~clk;

  frame_scaler_reader #(
    .AW(AW), .DW(8), .SRC_W(SRC_W), .SRC_H(SRC_H),
    .DISP_W(640), .DISP_H(480), .RAM_LAT(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .scale        (scale),
    .win_x        (win_x),
    .win_y        (win_y),
    .border_color (border_color),
    .posX         (posX),
    .posY         (posY),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .pixel_out    (pixel_out),
    .in_window    (in_window),
    .frame_start  (frame_start)
  );

  logic [7:0] ram [0:NPIX-1];
  always @(posedge clk) mem_data <= (int'(mem_addr) < NPIX) ? ram[mem_addr] : 8'h00;

  int n_checks = 0;
  int n_errors = 0;
  int frames_driven = 0;
  int fs_seen = 0;
  int max_addr = 0;
  bit track_max = 0;
  bit rnd_cfg = 0;

  function automatic void check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Reference model: window membership and address from plain coordinates.
  bit         model_ready = 0;
  bit         m_valid, m_prev_origin;
  int         m_s, m_wx, m_wy;
  logic [7:0] m_border;
  bit         hh0, hh1;
  int         ha0, ha1;
  int         exp_addr, exp_pix;
  bit         exp_fs, exp_inw;

  always @(posedge clk) begin : model
    bit origin, fsd, hit;
    int f, dx, dy, a;
    if (rst) begin
      m_valid = 0; m_prev_origin = 0; m_s = 0; m_wx = 0; m_wy = 0; m_border = 8'h00;
      hh0 = 0; hh1 = 0; ha0 = 0; ha1 = 0;
      exp_addr = 0; exp_pix = 0; exp_fs = 0; exp_inw = 0;
    end else begin
      exp_inw = hh1;
      exp_pix = hh1 ? int'(ram[ha1]) : int'(m_border);
      origin = (posX == 10'd0) && (posY == 9'd0);
      fsd = origin && !m_prev_origin;
      m_prev_origin = origin;
      if (fsd) begin
        m_valid  = 1;
        m_s      = (scale == 2'd3) ? 0 : int'(scale);
        m_wx     = int'(win_x);
        m_wy     = int'(win_y);
        m_border = border_color;
      end
      f  = 1 << m_s;
      dx = int'(posX) - m_wx;
      dy = int'(posY) - m_wy;
      hit = m_valid && dx >= 0 && dx < SRC_W * f && int'(posX) < 640 &&
            dy >= 0 && dy < SRC_H * f && int'(posY) < 480;
      a = hit ? (dy / f) * SRC_W + dx / f : 0;
      hh1 = hh0; ha1 = ha0; hh0 = hit; ha0 = a;
      exp_addr = a;
      exp_fs   = fsd;
    end
    model_ready = 1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      check("mem_addr", int'(mem_addr), exp_addr);
      check("frame_start", int'(frame_start), int'(exp_fs));
      check("in_window", int'(in_window), int'(exp_inw));
      check("pixel_out", int'(pixel_out), exp_pix);
      if (frame_start) fs_seen++;
      if (track_max && int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
    end
  end

  task automatic drive(input int x, input int y);
    posX = 10'(x);
    posY = 9'(y);
    if (rnd_cfg) begin
      scale        = 2'($urandom);
      win_x        = 10'($urandom_range(400, 0));
      win_y        = 9'($urandom_range(300, 0));
      border_color = 8'($urandom);
    end
    @(posedge clk);
    #1;
  endtask

  int    pr_x[$], pr_y[$], pr_a[$], pr_i[$];
  string pr_n[$];

  task automatic add_probe(input string n, input int x, input int y, input int a, input int i);
    pr_n.push_back(n); pr_x.push_back(x); pr_y.push_back(y);
    pr_a.push_back(a); pr_i.push_back(i);
  endtask

  // Holding the same position three cycles lets the pixel catch up.
  task automatic probe(input string n, input int x, input int y, input int a, input int i);
    drive(x, y);
    check({n, "_addr"}, int'(mem_addr), a);
    drive(x, y);
    drive(x, y);
    check({n, "_inw"}, int'(in_window), i);
    check({n, "_pix"}, int'(pixel_out), (i != 0) ? int'(ram[a]) : int'(border_color));
  endtask

  task automatic run_frame(input int sc, input int wx, input int wy, input logic [7:0] bc,
                           input bit rnd, input int sc_at_200, input bit rst_mid);
    scale = 2'(sc); win_x = 10'(wx); win_y = 9'(wy); border_color = bc;
    rnd_cfg = rnd;
    frames_driven++;
    for (int y = 0; y < NLINES; y++) begin
      if (sc_at_200 >= 0 && y == 200) scale = 2'(sc_at_200);
      if (y == 0) drive(0, 0);
      for (int k = 0; k < 3; k++) drive(int'($urandom_range(799, 1)), y);
      for (int p = 0; p < pr_y.size(); p++)
        if (pr_y[p] == y) probe(pr_n[p], pr_x[p], pr_y[p], pr_a[p], pr_i[p]);
      if (rst_mid && y == 100) begin
        posX = 10'd300; posY = 9'd100; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_addr", int'(mem_addr), 0);
        check("midrst_pix", int'(pixel_out), 0);
        check("midrst_inw", int'(in_window), 0);
        check("midrst_fs", int'(frame_start), 0);
      end
    end
    rnd_cfg = 0;
    pr_n.delete(); pr_x.delete(); pr_y.delete(); pr_a.delete(); pr_i.delete();
  endtask

  initial begin
    foreach (ram[i]) ram[i] = 8'($urandom);
    rst = 1'b1; posX = 10'd400; posY = 9'd300;
    scale = 2'd0; win_x = '0; win_y = '0; border_color = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    check("rst_addr", int'(mem_addr), 0);
    check("rst_pix", int'(pixel_out), 0);
    check("rst_inw", int'(in_window), 0);
    check("rst_fs", int'(frame_start), 0);
    rst = 1'b0;

    add_probe("x1_5_2", 5, 2, 325, 1);
    run_frame(0, 0, 0, RED, 0, -1, 0);

    add_probe("x2_101_51", 101, 51, 0, 1);
    add_probe("x2_103_53", 103, 53, 161, 1);
    add_probe("x2_99_60", 99, 60, 0, 0);
    run_frame(1, 100, 50, BLUE, 0, -1, 0);

    add_probe("x4_320_240", 320, 240, 9680, 1);
    add_probe("x4_639_479", 639, 479, 19199, 1);
    run_frame(2, 0, 0, GREEN, 0, -1, 0);

    add_probe("rsv_5_2", 5, 2, 325, 1);
    run_frame(3, 0, 0, RED, 0, -1, 0);

    add_probe("clip_639_479", 639, 479, 12679, 1);
    max_addr = 0;
    track_max = 1;
    run_frame(0, 600, 400, BLUE, 0, -1, 0);
    track_max = 0;
    check("clip_max_addr", max_addr, 12679);

    add_probe("cfg_hold_x1", 10, 210, 9610, 1);
    run_frame(0, 0, 150, GREEN, 0, 1, 0);
    add_probe("cfg_new_x2", 10, 210, 4805, 1);
    run_frame(1, 0, 150, GREEN, 0, -1, 0);

    run_frame(2, 0, 0, RED, 0, -1, 1);
    add_probe("post_rst_x4", 5, 2, 1, 1);
    run_frame(2, 0, 0, RED, 0, -1, 0);

    for (int r = 0; r < 3; r++) run_frame(0, 0, 0, BLACK, 1, -1, 0);

    repeat (4) drive(700, 499);
    check("frame_start_count", fs_seen, frames_driven);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_scaler_reader.md
# frame_scaler_reader

Read-side address generator and pixel formatter between the dual-port frame buffer and the 640x480 VGA driver. Maps the driver's `posX`/`posY` onto a SRC_W x SRC_H camera frame placed at a programmable offset, with integer upscale x1/x2/x4. Emits a border colour outside the window and tracks frame boundaries so configuration changes never tear a frame. Runs entirely in the 25 MHz VGA clock domain.

## Interface
- AW, 15: frame-buffer address width
- DW, 8: pixel width (RGB332)
- SRC_W, 160: source frame width in pixels
- SRC_H, 120: source frame height in pixels
- DISP_W, 640: display width
- DISP_H, 480: display height
- RAM_LAT, 1: read latency of the buffer, in clk cycles (≥1)

Ports:
- clk  in  1  pixel clock (25 MHz); the only clock
- rst  in  1  synchronous, active-high reset
- scale  in  2  0 = x1, 1 = x2, 2 = x4, 3 = reserved (treated as x1)
- win_x  in  10  window left edge, display coordinates
- win_y  in  9  window top edge
- border_color  in  DW  colour shown outside the window
- posX  in  10  next pixel column from the VGA driver
- posY  in  9  next pixel row from the VGA driver
- mem_addr  out  AW  frame-buffer read address
- mem_data  in  DW  frame-buffer read data, valid RAM_LAT cycles after mem_addr
- pixel_out  out  DW  pixel to the VGA driver
- in_window  out  1  pixel_out comes from the buffer (aligned with pixel_out)
- frame_start  out  1  one-cycle pulse when a new frame begins

## Operation
- **Frame start:** the cycle where (posX, posY) becomes (0, 0) after having been anything else. That cycle:
  - latches scale, win_x, win_y and border_color into shadow registers;
  - pulses frame_start on the following cycle.
  - All other logic uses only the shadow values.
- **Vertical tracking FSM:**
  - States: WAIT_FRAME, ABOVE, IN_WIN, BELOW.
  - Reset → WAIT_FRAME. Frame start → ABOVE.
  - ABOVE → IN_WIN on the first line where posY == win_y.
  - IN_WIN → BELOW when posY − win_y reaches SRC_H<<s, or posY ≥ DISP_H.
  - BELOW → ABOVE only at the next frame start.
- **Row base (no multiplier):**
  - Entering IN_WIN: row_base = 0, sub_row = 0.
  - On each later new line (posY differs from its registered value) inside IN_WIN: if sub_row == (1<<s)−1, then sub_row = 0 and row_base += SRC_W; else sub_row += 1.
- **Column:**
  - rx = posX − win_x; sx = rx >> s.
  - Horizontal hit when posX ≥ win_x, rx < SRC_W<<s and posX < DISP_W.
- **Address:**
  - Hit = IN_WIN and horizontal hit.
  - mem_addr = row_base + sx when hit, else 0.
  - Width rule: row_base + sx ≤ SRC_W·SRC_H − 1, which must fit AW (checked at elaboration).
- **Output:**
  - pixel_out = mem_data when the delayed hit flag is set, else the shadow border_color.
  - in_window = delayed hit flag.
- **Clipping:** a window that extends past DISP_W/DISP_H is clipped; hidden source pixels are never addressed.

## Timing
- mem_addr is registered: valid 1 cycle after posX/posY.
- pixel_out and in_window are registered: valid RAM_LAT + 2 cycles after posX/posY. The hit flag rides a matching delay line.
- Reset values:
  - mem_addr = 0, pixel_out = 0, in_window = 0, frame_start = 0;
  - FSM in WAIT_FRAME, shadow registers = 0 (x1 scale, window at 0,0, border black).
- Reset mid-frame: output stays border/0 (in_window = 0) until the next frame start. No partial-frame addressing.
- Config inputs changing mid-frame have no effect until the next frame start.
- frame_start and a new line in the same cycle: frame start wins and row state clears.

## Structure
- Shared package `cam_vga_pkg` holds:
  - the scale encoding constants (SCALE_X1/X2/X4);
  - RGB332 colour constants (RED/GREEN/BLUE/BLACK);
  - the FSM state encoding.
- One sub-module, `scaled_row_counter`: the vertical FSM plus row_base/sub_row. Inputs are posY, the shadow config and the frame-start strobe; output is row_base plus an IN_WIN flag. The column and pipeline logic stay in the top module.

## Test plan
- **x1, window (0,0), RAM_LAT = 1:** pos (5,2) → mem_addr = 325 one cycle later; pixel_out = mem_data(325) and in_window = 1, three cycles after pos.
- **x2, window (100,50):**
  - pos (101,51) → mem_addr = 0;
  - pos (103,53) → mem_addr = 161;
  - pos (99,60) → in_window = 0, pixel_out = border_color.
- **x4, window (0,0):** pos (639,479) → mem_addr = 19199; the whole display is in-window.
- **Frame-boundary config:** change scale from x1 to x2 at posY = 200 → addressing stays x1 until (0,0). Then frame_start pulses once and x2 mapping applies.
- **Reset and reserved scale:** assert rst at pos (300,100) → all outputs 0 next cycle and in_window = 0 until the next frame start. scale = 3 → mapping identical to x1.
- **Clipping:** window (600,400), x1 → pos (639,479) gives addr 79·160 + 39 = 12679; no address beyond it is issued.
